// File: rtl/roi_capture_ctrl.sv
// ============================================================================
//  roi_capture_ctrl
//  Sequences one frame of ROI buffer writes, then holds the buffer for the reader.
//  Revision 1.0
// ============================================================================
`default_nettype none

module roi_capture_ctrl #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter logic [23:0] TIMEOUT  = 24'd5_000_000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iArm,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic        iRelease,
    output logic        oWrEn,
    output logic [7:0]  oRow,
    output logic [8:0]  oCol,
    output logic        oStart,
    output logic        oDone,
    output logic        oFrameReady,
    output logic        oBusy,
    output logic        oError,
    output logic [16:0] oPixCount
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_SOF = 3'd1;
    localparam logic [2:0] S_CAPTURE  = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;

    localparam logic [16:0] C_TOTAL    = 17'(H_ACTIVE * V_ACTIVE);
    localparam logic [8:0]  C_COL_LAST = 9'(H_ACTIVE - 1);

    logic [2:0]  state_q, state_d;
    logic        fval_q;
    logic [7:0]  row_q, row_d;
    logic [8:0]  col_q, col_d;
    logic [16:0] pix_q, pix_d;
    logic        err_q, err_d;
    logic [23:0] tmo_q, tmo_d;

    logic sof, eof, full, wr_window, wq, overrun;

    assign sof  = iFVAL & ~fval_q;
    assign eof  = ~iFVAL & fval_q;
    assign full = (pix_q == C_TOTAL);

    // The SOF cycle itself is writable so the first pixel lands at (0,0).
    assign wr_window = (state_q == S_CAPTURE) | ((state_q == S_WAIT_SOF) & sof);
    assign wq        = wr_window & iFVAL & iDVAL & ~full;
    assign overrun   = wr_window & iFVAL & iDVAL & full;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pix_d   = pix_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (iArm) begin
                    state_d = S_WAIT_SOF;
                    err_d   = 1'b0;
                    pix_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    tmo_d   = '0;
                end
            end
            S_WAIT_SOF: begin
                if (sof) begin
                    state_d = S_CAPTURE;
                end else if (tmo_q == TIMEOUT - 24'd1) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            S_CAPTURE: begin
                if (eof) begin
                    state_d = S_DONE;
                    if (pix_q != C_TOTAL) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (iRelease) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // wq only fires in WAIT_SOF/CAPTURE, so it never collides with the IDLE clear.
        if (wq) begin
            pix_d = pix_q + 17'd1;
            if (col_q == C_COL_LAST) begin
                col_d = '0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end

        if (overrun) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            fval_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            fval_q  <= iFVAL;
            row_q   <= row_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign oWrEn       = wq;
    assign oRow        = row_q;
    assign oCol        = col_q;
    assign oPixCount   = pix_q;
    assign oError      = err_q;
    assign oStart      = (state_q == S_CAPTURE);
    assign oDone       = (state_q == S_DONE);
    assign oFrameReady = (state_q == S_HOLD);
    assign oBusy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_roi_capture_ctrl.sv
// ============================================================================
//  tb_roi_capture_ctrl
//  Scoreboard bench: stimulus queues expected writes/done cycles, monitor compares.
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_roi_capture_ctrl;

    localparam int H     = 20;
    localparam int V     = 12;
    localparam int TOTAL = H * V;
    localparam int TMO   = 100;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iArm = 1'b0;
    logic        iFVAL = 1'b0;
    logic        iDVAL = 1'b0;
    logic        iRelease = 1'b0;
    logic        oWrEn;
    logic [7:0]  oRow;
    logic [8:0]  oCol;
    logic        oStart;
    logic        oDone;
    logic        oFrameReady;
    logic        oBusy;
    logic        oError;
    logic [16:0] oPixCount;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    logic [16:0] exp_q[$];
    int          exp_done[$];

    roi_capture_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .TIMEOUT  (24'(TMO))
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iArm        (iArm),
        .iFVAL       (iFVAL),
        .iDVAL       (iDVAL),
        .iRelease    (iRelease),
        .oWrEn       (oWrEn),
        .oRow        (oRow),
        .oCol        (oCol),
        .oStart      (oStart),
        .oDone       (oDone),
        .oFrameReady (oFrameReady),
        .oBusy       (oBusy),
        .oError      (oError),
        .oPixCount   (oPixCount)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc_n <= cyc_n + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [16:0] addr_of(input int k);
        return {8'(k / H), 9'(k % H)};
    endfunction

    // Monitor: every write and every done pulse must match the scoreboard.
    always @(negedge iCLK) begin
        if (oWrEn !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got row %0d col %0d expected no write", oRow, oCol);
            end else begin
                check("wr_addr", 32'({oRow, oCol}), 32'(exp_q.pop_front()));
            end
        end
        if (oDone !== 1'b0) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc_n);
            end else begin
                check("done_cycle", 32'(cyc_n), 32'(exp_done.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic arm();
        iArm = 1'b1;
        cyc();
        iArm = 1'b0;
        check("busy_after_arm", 32'(oBusy), 32'd1);
    endtask

    task automatic release_buf();
        iRelease = 1'b1;
        cyc();
        iRelease = 1'b0;
        check("ready_after_release", 32'(oFrameReady), 32'd0);
        check("busy_after_release", 32'(oBusy), 32'd0);
    endtask

    // One frame: npix pixels, 3-cycle gaps between rows, then EOF and idle cycles
    // with iDVAL high but iFVAL low (must be ignored).
    task automatic send_frame(input int npix, input bit exp_cap, input int arm_at, input int rst_at);
        bit cap;
        cap = exp_cap;
        for (int k = 0; k < npix; k++) begin
            iFVAL = 1'b1;
            iDVAL = 1'b1;
            iArm  = (k == arm_at);
            if (k == rst_at) cap = 1'b0;
            if (cap && k < TOTAL) exp_q.push_back(addr_of(k));
            if (exp_cap && k == 0) check("start_low_in_sof", 32'(oStart), 32'd0);
            if (k == rst_at) begin
                iRST = 1'b0;
                #1;
                check("rst_busy", 32'(oBusy), 32'd0);
                check("rst_flags", 32'({oWrEn, oStart, oDone, oFrameReady, oError}), 32'd0);
                check("rst_addr", 32'({oRow, oCol}), 32'd0);
                check("rst_pixcount", 32'(oPixCount), 32'd0);
            end
            cyc();
            if (k == rst_at) iRST = 1'b1;
            if (exp_cap && k == 0 && rst_at != 0) check("start_after_sof", 32'(oStart), 32'd1);
            iArm = 1'b0;
            if ((k % H) == H - 1 && k != npix - 1) begin
                iDVAL = 1'b0;
                repeat (3) cyc();
            end
        end
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        if (cap) exp_done.push_back(cyc_n + 1);
        cyc();
        iDVAL = 1'b1;
        repeat (4) cyc();
        iDVAL = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        check("reset_flags", 32'({oWrEn, oStart, oDone, oFrameReady, oBusy, oError}), 32'd0);
        check("reset_addr", 32'({oRow, oCol}), 32'd0);
        check("reset_pixcount", 32'(oPixCount), 32'd0);
        iRST = 1'b1;
        repeat (2) cyc();

        // Nominal frame
        arm();
        repeat (3) cyc();
        send_frame(TOTAL, 1'b1, -1, -1);
        check("nom_pixcount", 32'(oPixCount), 32'(TOTAL));
        check("nom_error", 32'(oError), 32'd0);
        check("nom_addr_end", 32'({oRow, oCol}), 32'(addr_of(TOTAL)));
        repeat (10) cyc();
        check("nom_ready_held", 32'(oFrameReady), 32'd1);
        release_buf();

        // Arm mid-frame: that frame is skipped, next one captured
        send_frame(TOTAL, 1'b0, 200, -1);
        send_frame(TOTAL, 1'b1, -1, -1);
        check("mid_pixcount", 32'(oPixCount), 32'(TOTAL));
        check("mid_error", 32'(oError), 32'd0);
        release_buf();

        // Short frame
        arm();
        send_frame(50, 1'b1, -1, -1);
        check("short_error", 32'(oError), 32'd1);
        check("short_pixcount", 32'(oPixCount), 32'd50);
        check("short_addr", 32'({oRow, oCol}), 32'({8'd2, 9'd10}));
        check("short_ready", 32'(oFrameReady), 32'd1);
        release_buf();

        // Overrun
        arm();
        send_frame(TOTAL + 10, 1'b1, -1, -1);
        check("ovr_error", 32'(oError), 32'd1);
        check("ovr_pixcount", 32'(oPixCount), 32'(TOTAL));
        check("ovr_addr_frozen", 32'({oRow, oCol}), 32'({8'(V), 9'd0}));
        release_buf();

        // Hold protection: frame plus arm during HOLD must not write
        arm();
        send_frame(TOTAL, 1'b1, -1, -1);
        send_frame(TOTAL, 1'b0, 3, -1);
        check("hold_ready", 32'(oFrameReady), 32'd1);
        check("hold_pixcount", 32'(oPixCount), 32'(TOTAL));
        check("hold_error", 32'(oError), 32'd0);
        release_buf();

        // Timeout with iFVAL held low
        arm();
        repeat (TMO - 1) cyc();
        check("tmo_busy_before", 32'(oBusy), 32'd1);
        check("tmo_error_before", 32'(oError), 32'd0);
        cyc();
        check("tmo_busy_after", 32'(oBusy), 32'd0);
        check("tmo_error_after", 32'(oError), 32'd1);
        arm();
        check("arm_clears_error", 32'(oError), 32'd0);

        // Async reset mid-capture, then a clean frame
        send_frame(TOTAL, 1'b1, -1, 100);
        check("post_rst_busy", 32'(oBusy), 32'd0);
        check("post_rst_ready", 32'(oFrameReady), 32'd0);
        arm();
        send_frame(TOTAL, 1'b1, -1, -1);
        check("clean_pixcount", 32'(oPixCount), 32'(TOTAL));
        check("clean_error", 32'(oError), 32'd0);
        release_buf();

        repeat (3) cyc();
        check("writes_left", 32'(exp_q.size()), 32'd0);
        check("dones_left", 32'(exp_done.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
